// File: rtl/bp_be_dcache_port_arbiter.sv
// D$ port arbiter between the pipeline and the page-table walker.
// Tracks op ownership through TL/TV to steer tags and data-valid.
module bp_be_dcache_port_arbiter #(
    parameter int page_offset_width_p = 12,
    parameter int dpath_width_p = 64,
    parameter int ptag_width_p = 28,
    parameter int starve_limit_p = 4,
    localparam int opcode_width_lp = 4,
    localparam int pkt_width_lp = opcode_width_lp
                                + page_offset_width_p
                                + dpath_width_p
) (
    input  logic                    clk_i,
    input  logic                    reset_n_i,
    input  logic                    pipe_v_i,
    output logic                    pipe_ready_o,
    input  logic [pkt_width_lp-1:0] pipe_pkt_i,
    input  logic [ptag_width_p-1:0] pipe_ptag_i,
    input  logic                    pipe_ptag_v_i,
    input  logic                    ptw_v_i,
    output logic                    ptw_ready_o,
    input  logic [pkt_width_lp-1:0] ptw_pkt_i,
    input  logic [ptag_width_p-1:0] ptw_ptag_i,
    input  logic                    ptw_ptag_v_i,
    input  logic                    ptw_busy_i,
    input  logic                    flush_i,
    output logic                    dcache_v_o,
    output logic [pkt_width_lp-1:0] dcache_pkt_o,
    output logic [ptag_width_p-1:0] dcache_ptag_o,
    output logic                    dcache_ptag_v_o,
    input  logic                    dcache_ready_i,
    input  logic                    dcache_early_v_i,
    output logic                    pipe_early_v_o,
    output logic                    ptw_early_v_o,
    output logic                    ptw_grant_o
);

    localparam int starve_w_lp =
        (starve_limit_p > 1) ? $clog2(starve_limit_p) : 1;
    localparam logic [starve_w_lp-1:0] starve_max_lp =
        starve_w_lp'(starve_limit_p - 1);

    typedef enum logic [1:0] {
        e_idle  = 2'd0,
        e_drain = 2'd1,
        e_lock  = 2'd2
    } state_e;

    state_e state_q, state_d;

    logic [starve_w_lp-1:0] starve_q, starve_d;

    // owner bit: 1 = walker, 0 = pipeline
    logic tl_v_q, tl_v_d;
    logic tl_owner_q, tl_owner_d;
    logic tv_v_q, tv_v_d;
    logic tv_owner_q, tv_owner_d;

    logic ptw_win;
    logic pipe_in_flight;
    logic ptw_in_flight;

    // PTW takes the port when the pipe is idle or has starved it long enough
    always_comb begin
        ptw_win = (state_q == e_idle) & ptw_v_i
                & (~pipe_v_i | (starve_q == starve_max_lp));
        pipe_in_flight = (tl_v_q & ~tl_owner_q)
                       | (tv_v_q & ~tv_owner_q);
        ptw_in_flight = (tl_v_q & tl_owner_q)
                      | (tv_v_q & tv_owner_q);
    end

    // state register
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= e_idle;
        end else begin
            state_q <= state_d;
        end
    end

    // next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            e_idle: begin
                if (ptw_win) state_d = e_drain;
            end
            e_drain: begin
                if (!pipe_in_flight && dcache_ready_i)
                    state_d = e_lock;
            end
            e_lock: begin
                if (!ptw_busy_i && !ptw_v_i && !ptw_in_flight)
                    state_d = e_idle;
            end
            default: state_d = e_idle;
        endcase
    end

    // port outputs; everything is held low while reset is asserted
    always_comb begin
        pipe_ready_o = 1'b0;
        ptw_ready_o = 1'b0;
        dcache_v_o = 1'b0;
        dcache_pkt_o = pipe_pkt_i;
        ptw_grant_o = 1'b0;
        unique case (state_q)
            e_idle: begin
                pipe_ready_o = dcache_ready_i & ~ptw_win;
                dcache_v_o = pipe_v_i & dcache_ready_i & ~ptw_win;
            end
            e_drain: begin
                dcache_v_o = 1'b0;
            end
            e_lock: begin
                ptw_ready_o = dcache_ready_i;
                dcache_v_o = ptw_v_i & dcache_ready_i;
                dcache_pkt_o = ptw_pkt_i;
                ptw_grant_o = 1'b1;
            end
            default: begin
                dcache_v_o = 1'b0;
            end
        endcase

        dcache_ptag_o = '0;
        dcache_ptag_v_o = 1'b0;
        if (tl_v_q) begin
            if (tl_owner_q) begin
                dcache_ptag_o = ptw_ptag_i;
                dcache_ptag_v_o = ptw_ptag_v_i;
            end else begin
                dcache_ptag_o = pipe_ptag_i;
                dcache_ptag_v_o = pipe_ptag_v_i & ~flush_i;
            end
        end

        pipe_early_v_o = dcache_early_v_i & tv_v_q & ~tv_owner_q;
        ptw_early_v_o = dcache_early_v_i & tv_v_q & tv_owner_q;

        if (!reset_n_i) begin
            pipe_ready_o = 1'b0;
            ptw_ready_o = 1'b0;
            dcache_v_o = 1'b0;
            dcache_pkt_o = '0;
            dcache_ptag_o = '0;
            dcache_ptag_v_o = 1'b0;
            pipe_early_v_o = 1'b0;
            ptw_early_v_o = 1'b0;
            ptw_grant_o = 1'b0;
        end
    end

    // starvation counter and TL/TV ownership tracking
    always_comb begin
        starve_d = '0;
        if (state_q == e_idle && ptw_v_i && !ptw_win) begin
            if (starve_q != starve_max_lp)
                starve_d = starve_q + 1'b1;
            else
                starve_d = starve_q;
        end

        tl_v_d = dcache_v_o;
        tl_owner_d = (state_q == e_lock);
        // a flush kills only pipeline ops leaving the tag stage
        tv_v_d = tl_v_q & ~(flush_i & ~tl_owner_q);
        tv_owner_d = tl_owner_q;
    end

    // counter and stage registers
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            starve_q <= '0;
            tl_v_q <= 1'b0;
            tl_owner_q <= 1'b0;
            tv_v_q <= 1'b0;
            tv_owner_q <= 1'b0;
        end else begin
            starve_q <= starve_d;
            tl_v_q <= tl_v_d;
            tl_owner_q <= tl_owner_d;
            tv_v_q <= tv_v_d;
            tv_owner_q <= tv_owner_d;
        end
    end

endmodule

// File: tb/tb_bp_be_dcache_port_arbiter.sv
// Directed bench for the D$ port arbiter.
// Inputs change on negedge; outputs sampled 1ns later.
module tb_bp_be_dcache_port_arbiter;

    localparam int pw = 80;
    localparam int tw = 28;

    logic          clk_i = 1'b0;
    logic          reset_n_i;
    logic          pipe_v_i;
    logic          pipe_ready_o;
    logic [pw-1:0] pipe_pkt_i;
    logic [tw-1:0] pipe_ptag_i;
    logic          pipe_ptag_v_i;
    logic          ptw_v_i;
    logic          ptw_ready_o;
    logic [pw-1:0] ptw_pkt_i;
    logic [tw-1:0] ptw_ptag_i;
    logic          ptw_ptag_v_i;
    logic          ptw_busy_i;
    logic          flush_i;
    logic          dcache_v_o;
    logic [pw-1:0] dcache_pkt_o;
    logic [tw-1:0] dcache_ptag_o;
    logic          dcache_ptag_v_o;
    logic          dcache_ready_i;
    logic          dcache_early_v_i;
    logic          pipe_early_v_o;
    logic          ptw_early_v_o;
    logic          ptw_grant_o;

    int checks = 0;
    int passed = 0;

    bp_be_dcache_port_arbiter dut (
        .clk_i           (clk_i),
        .reset_n_i       (reset_n_i),
        .pipe_v_i        (pipe_v_i),
        .pipe_ready_o    (pipe_ready_o),
        .pipe_pkt_i      (pipe_pkt_i),
        .pipe_ptag_i     (pipe_ptag_i),
        .pipe_ptag_v_i   (pipe_ptag_v_i),
        .ptw_v_i         (ptw_v_i),
        .ptw_ready_o     (ptw_ready_o),
        .ptw_pkt_i       (ptw_pkt_i),
        .ptw_ptag_i      (ptw_ptag_i),
        .ptw_ptag_v_i    (ptw_ptag_v_i),
        .ptw_busy_i      (ptw_busy_i),
        .flush_i         (flush_i),
        .dcache_v_o      (dcache_v_o),
        .dcache_pkt_o    (dcache_pkt_o),
        .dcache_ptag_o   (dcache_ptag_o),
        .dcache_ptag_v_o (dcache_ptag_v_o),
        .dcache_ready_i  (dcache_ready_i),
        .dcache_early_v_i(dcache_early_v_i),
        .pipe_early_v_o  (pipe_early_v_o),
        .ptw_early_v_o   (ptw_early_v_o),
        .ptw_grant_o     (ptw_grant_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic drive_quiet();
        pipe_v_i = 1'b0;
        pipe_pkt_i = '0;
        pipe_ptag_i = '0;
        pipe_ptag_v_i = 1'b0;
        ptw_v_i = 1'b0;
        ptw_pkt_i = '0;
        ptw_ptag_i = '0;
        ptw_ptag_v_i = 1'b0;
        ptw_busy_i = 1'b0;
        flush_i = 1'b0;
        dcache_ready_i = 1'b1;
        dcache_early_v_i = 1'b0;
    endtask

    task automatic test_reset();
        reset_n_i = 1'b0;
        drive_quiet();
        pipe_v_i = 1'b1;
        pipe_pkt_i = 80'hABCD;
        ptw_v_i = 1'b1;
        dcache_early_v_i = 1'b1;
        #1;
        checks++;
        if (dcache_v_o !== 1'b0)
            $display("FAIL rst_dcache_v got %b want 0", dcache_v_o);
        else passed++;
        checks++;
        if (pipe_ready_o !== 1'b0)
            $display("FAIL rst_pipe_ready got %b want 0", pipe_ready_o);
        else passed++;
        checks++;
        if (dcache_pkt_o !== '0)
            $display("FAIL rst_pkt got %h want 0", dcache_pkt_o);
        else passed++;
        checks++;
        if ({ptw_ready_o, ptw_grant_o, dcache_ptag_v_o,
             pipe_early_v_o, ptw_early_v_o} !== 5'b0)
            $display("FAIL rst_misc got %b want 00000",
                     {ptw_ready_o, ptw_grant_o, dcache_ptag_v_o,
                      pipe_early_v_o, ptw_early_v_o});
        else passed++;
        @(negedge clk_i);
        @(negedge clk_i);
        reset_n_i = 1'b1;
        drive_quiet();
        #1;
        checks++;
        if (pipe_ready_o !== 1'b1 || ptw_grant_o !== 1'b0)
            $display("FAIL post_rst_idle got ready=%b grant=%b want 1/0",
                     pipe_ready_o, ptw_grant_o);
        else passed++;
    endtask

    task automatic test_back_to_back();
        logic e_dv, e_early, e_tv;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk_i);
            drive_quiet();
            pipe_v_i = (k < 3);
            pipe_pkt_i = 80'h1000 + 80'(k);
            pipe_ptag_i = 28'h200 + 28'(k);
            pipe_ptag_v_i = 1'b1;
            dcache_early_v_i = 1'b1;
            #1;
            e_dv = (k < 3);
            e_tv = (k >= 1 && k <= 3);
            e_early = (k >= 2 && k <= 4);
            checks++;
            if (dcache_v_o !== e_dv)
                $display("FAIL b2b_dv c%0d got %b want %b", k, dcache_v_o, e_dv);
            else passed++;
            checks++;
            if (dcache_pkt_o !== pipe_pkt_i)
                $display("FAIL b2b_pkt c%0d got %h want %h",
                         k, dcache_pkt_o, pipe_pkt_i);
            else passed++;
            checks++;
            if (dcache_ptag_v_o !== e_tv)
                $display("FAIL b2b_ptag_v c%0d got %b want %b",
                         k, dcache_ptag_v_o, e_tv);
            else passed++;
            if (e_tv) begin
                checks++;
                if (dcache_ptag_o !== pipe_ptag_i)
                    $display("FAIL b2b_ptag c%0d got %h want %h",
                             k, dcache_ptag_o, pipe_ptag_i);
                else passed++;
            end
            checks++;
            if (pipe_early_v_o !== e_early || ptw_early_v_o !== 1'b0)
                $display("FAIL b2b_early c%0d got %b%b want %b0",
                         k, pipe_early_v_o, ptw_early_v_o, e_early);
            else passed++;
        end
    endtask

    task automatic test_starve();
        logic e_dv, e_pr, e_wr, e_gr, e_pe, e_we, e_tv;
        for (int k = 0; k < 11; k++) begin
            @(negedge clk_i);
            drive_quiet();
            pipe_v_i = (k <= 6);
            pipe_pkt_i = 80'h2000 + 80'(k);
            pipe_ptag_i = 28'h300;
            pipe_ptag_v_i = 1'b1;
            ptw_v_i = (k <= 6);
            ptw_pkt_i = 80'h9000 + 80'(k);
            ptw_ptag_i = 28'h777;
            ptw_ptag_v_i = 1'b1;
            ptw_busy_i = (k >= 3 && k <= 7);
            dcache_early_v_i = 1'b1;
            #1;
            e_dv = (k < 3) || (k == 6);
            e_pr = (k < 3) || (k == 10);
            e_wr = (k >= 6 && k <= 9);
            e_gr = (k >= 6 && k <= 9);
            e_pe = (k >= 2 && k <= 4);
            e_we = (k == 8);
            e_tv = (k >= 1 && k <= 3) || (k == 7);
            checks++;
            if (dcache_v_o !== e_dv)
                $display("FAIL stv_dv c%0d got %b want %b", k, dcache_v_o, e_dv);
            else passed++;
            checks++;
            if (pipe_ready_o !== e_pr)
                $display("FAIL stv_pready c%0d got %b want %b",
                         k, pipe_ready_o, e_pr);
            else passed++;
            checks++;
            if (ptw_ready_o !== e_wr)
                $display("FAIL stv_wready c%0d got %b want %b",
                         k, ptw_ready_o, e_wr);
            else passed++;
            checks++;
            if (ptw_grant_o !== e_gr)
                $display("FAIL stv_grant c%0d got %b want %b",
                         k, ptw_grant_o, e_gr);
            else passed++;
            checks++;
            if (pipe_early_v_o !== e_pe || ptw_early_v_o !== e_we)
                $display("FAIL stv_early c%0d got %b%b want %b%b",
                         k, pipe_early_v_o, ptw_early_v_o, e_pe, e_we);
            else passed++;
            checks++;
            if (dcache_ptag_v_o !== e_tv)
                $display("FAIL stv_ptag_v c%0d got %b want %b",
                         k, dcache_ptag_v_o, e_tv);
            else passed++;
            if (k == 6) begin
                checks++;
                if (dcache_pkt_o !== 80'h9006)
                    $display("FAIL stv_ptw_pkt got %h want 9006", dcache_pkt_o);
                else passed++;
            end
            if (k == 7) begin
                checks++;
                if (dcache_ptag_o !== 28'h777)
                    $display("FAIL stv_ptw_ptag got %h want 777", dcache_ptag_o);
                else passed++;
            end
        end
    endtask

    task automatic test_ptw_idle_ready();
        logic e_dv, e_pr, e_wr, e_gr, e_we;
        for (int k = 0; k < 9; k++) begin
            @(negedge clk_i);
            drive_quiet();
            ptw_v_i = (k <= 4);
            ptw_pkt_i = 80'hA000 + 80'(k);
            ptw_busy_i = (k <= 5);
            dcache_ready_i = !(k == 2 || k == 3);
            dcache_early_v_i = 1'b1;
            #1;
            e_dv = (k == 4);
            e_pr = (k == 8);
            e_wr = (k >= 4 && k <= 7);
            e_gr = (k >= 2 && k <= 7);
            e_we = (k == 6);
            checks++;
            if (dcache_v_o !== e_dv)
                $display("FAIL ptw_dv c%0d got %b want %b", k, dcache_v_o, e_dv);
            else passed++;
            checks++;
            if (pipe_ready_o !== e_pr)
                $display("FAIL ptw_pready c%0d got %b want %b",
                         k, pipe_ready_o, e_pr);
            else passed++;
            checks++;
            if (ptw_ready_o !== e_wr)
                $display("FAIL ptw_wready c%0d got %b want %b",
                         k, ptw_ready_o, e_wr);
            else passed++;
            checks++;
            if (ptw_grant_o !== e_gr)
                $display("FAIL ptw_grant c%0d got %b want %b",
                         k, ptw_grant_o, e_gr);
            else passed++;
            checks++;
            if (ptw_early_v_o !== e_we || pipe_early_v_o !== 1'b0)
                $display("FAIL ptw_early c%0d got %b%b want 0%b",
                         k, pipe_early_v_o, ptw_early_v_o, e_we);
            else passed++;
            if (k == 4) begin
                checks++;
                if (dcache_pkt_o !== 80'hA004)
                    $display("FAIL ptw_pkt got %h want a004", dcache_pkt_o);
                else passed++;
            end
        end
    endtask

    task automatic test_flush();
        logic e_tv, e_pe;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk_i);
            drive_quiet();
            pipe_v_i = (k <= 2);
            pipe_pkt_i = 80'h3000 + 80'(k);
            pipe_ptag_v_i = 1'b1;
            flush_i = (k == 1);
            dcache_early_v_i = (k != 4);
            #1;
            e_tv = (k == 2) || (k == 3);
            e_pe = (k == 3);
            checks++;
            if (dcache_ptag_v_o !== e_tv)
                $display("FAIL fl_ptag_v c%0d got %b want %b",
                         k, dcache_ptag_v_o, e_tv);
            else passed++;
            checks++;
            if (pipe_early_v_o !== e_pe)
                $display("FAIL fl_early c%0d got %b want %b",
                         k, pipe_early_v_o, e_pe);
            else passed++;
        end
    endtask

    task automatic test_reset_lock();
        for (int k = 0; k < 4; k++) begin
            @(negedge clk_i);
            drive_quiet();
            ptw_v_i = 1'b1;
            ptw_busy_i = 1'b1;
            dcache_early_v_i = 1'b1;
        end
        #1;
        checks++;
        if (ptw_grant_o !== 1'b1)
            $display("FAIL rl_locked got %b want 1", ptw_grant_o);
        else passed++;
        @(negedge clk_i);
        ptw_v_i = 1'b0;
        #1;
        checks++;
        if (ptw_early_v_o !== 1'b1)
            $display("FAIL rl_tv_early got %b want 1", ptw_early_v_o);
        else passed++;
        reset_n_i = 1'b0;
        #1;
        checks++;
        if ({ptw_early_v_o, ptw_grant_o, ptw_ready_o,
             dcache_v_o, pipe_early_v_o} !== 5'b0)
            $display("FAIL rl_rst_out got %b want 00000",
                     {ptw_early_v_o, ptw_grant_o, ptw_ready_o,
                      dcache_v_o, pipe_early_v_o});
        else passed++;
        @(negedge clk_i);
        reset_n_i = 1'b1;
        drive_quiet();
        dcache_early_v_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++;
            if (ptw_grant_o !== 1'b0 || pipe_ready_o !== 1'b1)
                $display("FAIL rl_idle c%0d got grant=%b ready=%b want 0/1",
                         k, ptw_grant_o, pipe_ready_o);
            else passed++;
            checks++;
            if (ptw_early_v_o !== 1'b0 || pipe_early_v_o !== 1'b0)
                $display("FAIL rl_early c%0d got %b%b want 00",
                         k, pipe_early_v_o, ptw_early_v_o);
            else passed++;
            @(negedge clk_i);
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_starve();
        test_ptw_idle_ready();
        test_flush();
        test_reset_lock();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
